// File: rtl/unary_sched_pkg.sv
// Shared types and width helpers for the unary shift scheduler.
// Holds the scheduler state encoding and the magnitude-width helper so that
// the top and its arbiter agree on encodings without repeating arithmetic.
package unary_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // A magnitude must hold 0..N inclusive, hence N+1 codes.
  function automatic int mag_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_N = 16;
  localparam int DEF_R = 4;
  localparam int DEF_W = mag_width(DEF_N);

endpackage

// File: rtl/unary_shift_sched_rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter, search starts at (i_last+1) mod R.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own state.
// Ports: i_req request vector, i_last previous winner,
//        o_gnt one-hot grant (zero when no request), o_idx encoded winner.
module rr_arbiter #(
  parameter  int R  = 4,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [R-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    // Offsets 1..R visit every requester once, the previous winner last.
    for (int k = 1; k <= R; k++) begin
      w_cand = IW'((int'(i_last) + k) % R);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/unary_shift_sched.sv
// unary_shift_sched: round-robin sequencer serializing one requester's magnitude
//   into a shared SISO unary shift register (N LOAD cycles) and counting the
//   ones drained back (N DRAIN cycles).
// Latency: accept at edge T, done pulse in cycle T+2N+1, next accept at T+2N+2.
// Backpressure: req_ready is one-hot only in IDLE; requesters hold until accepted.
// Ports: clk/reset (sync, active-high); req_valid/req_value/req_ready request side;
//   sh_in/sh_shift drive the shared right-shifting register (reset_n = ~reset,
//   RIGHT=1, owned by the integrating level), sh_out is its LSB; busy, done,
//   done_id, result report the job; err is the sticky loopback mismatch flag.
// Optional: UNARY_SCHED_LOOPBACK_CHECK_EN enables the result-vs-magnitude
//   comparator; without it err is tied low.
module unary_shift_sched
  import unary_sched_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int R  = 4,
  parameter  int W  = mag_width(N),
  localparam int IW = (R > 1) ? $clog2(R) : 1,
  localparam int XW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [R-1:0]  req_valid,
  input  logic [R*W-1:0] req_value,
  output logic [R-1:0]  req_ready,
  output logic          sh_in,
  output logic          sh_shift,
  input  logic          sh_out,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] done_id,
  output logic [W-1:0]  result,
  output logic          err
);

  sched_state_e  r_state, w_state_nxt;
  logic [XW-1:0] r_idx;
  logic [W-1:0]  r_val, r_ones, r_result;
  logic [IW-1:0] r_id, r_last, r_done_id;
  logic [R-1:0]  w_gnt;
  logic [IW-1:0] w_gnt_idx;
  logic [W-1:0]  w_sel_val, w_sel_sat;
  logic          w_accept, w_idx_last;

  rr_arbiter #(.R(R)) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx)
  );

  // Grant only ever lands on a valid requester, so any ready bit is an accept.
  assign req_ready  = (r_state == IDLE && !reset) ? w_gnt : '0;
  assign w_accept   = |req_ready;
  assign w_idx_last = (r_idx == XW'(N - 1));

  always_comb begin
    w_sel_val = '0;
    for (int i = 0; i < R; i++) begin
      if (w_gnt[i]) w_sel_val = req_value[i*W +: W];
    end
  end

  assign w_sel_sat = (w_sel_val > W'(N)) ? W'(N) : w_sel_val;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = LOAD;
      LOAD:    if (w_idx_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_idx_last) w_state_nxt = DONE;
      DONE:                    w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_val     <= '0;
      r_ones    <= '0;
      r_id      <= '0;
      r_last    <= IW'(R - 1);
      r_result  <= '0;
      r_done_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_val  <= w_sel_sat;
            r_id   <= w_gnt_idx;
            r_last <= w_gnt_idx;
            r_idx  <= '0;
            r_ones <= '0;
          end
        end
        LOAD: r_idx <= w_idx_last ? '0 : r_idx + XW'(1);
        DRAIN: begin
          r_idx  <= w_idx_last ? '0 : r_idx + XW'(1);
          r_ones <= r_ones + W'(sh_out);
          // Publish on the final drain edge so result is a plain register
          // that already holds the full count during the DONE cycle.
          if (w_idx_last) begin
            r_result  <= r_ones + W'(sh_out);
            r_done_id <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign sh_shift = (r_state == LOAD) || (r_state == DRAIN);
  assign sh_in    = (r_state == LOAD) && (W'(r_idx) < r_val);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign done_id  = r_done_id;
  assign result   = r_result;

`ifdef UNARY_SCHED_LOOPBACK_CHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset)                                      r_err <= 1'b0;
    else if (r_state == DONE && r_ones != r_val)    r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_shift_sched.sv
// Directed bench for unary_shift_sched with a behavioural right-shifting
// SISO register closing the loop between sh_in and sh_out.
module tb_unary_shift_sched;
  localparam int N  = 16;
  localparam int R  = 4;
  localparam int W  = 5;
  localparam int IW = 2;

  logic           clk;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_value;
  logic [R-1:0]   req_ready;
  logic           sh_in, sh_shift, sh_out;
  logic           busy, done, err;
  logic [IW-1:0]  done_id;
  logic [W-1:0]   result;

  logic [N-1:0]   r_sr;
  logic           force_one;
  logic           w_sr_rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  unary_shift_sched #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .sh_in(sh_in), .sh_shift(sh_shift), .sh_out(sh_out),
    .busy(busy), .done(done), .done_id(done_id), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared shift register: async active-low reset, shifts right, LSB out.
  assign w_sr_rst_n = ~reset;
  always_ff @(posedge clk or negedge w_sr_rst_n) begin
    if (!w_sr_rst_n)   r_sr <= '0;
    else if (sh_shift) r_sr <= {sh_in, r_sr[N-1:1]};
  end
  assign sh_out = force_one ? 1'b1 : r_sr[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int v);
    req_valid[i] = 1'b1;
    req_value[i*W +: W] = W'(v);
  endtask

  // Entered in IDLE with requests presented; leaves one cycle after DONE.
  task automatic run_one(input string tag, input int exp_id, input int exp_sat,
                         input int exp_res, input bit withdraw, input bit exp_err);
    check({tag, "_rdy"}, req_ready, 32'(1 << exp_id));
    @(posedge clk); #1;
    if (withdraw) req_valid[exp_id] = 1'b0;
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_ld_shift%0d", tag, k), sh_shift, 1);
      check($sformatf("%s_ld_in%0d", tag, k), sh_in, (k < exp_sat) ? 1 : 0);
      check($sformatf("%s_ld_busy%0d", tag, k), {busy, done, req_ready}, {2'b10, 4'b0});
      @(posedge clk); #1;
    end
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_dr_shift_in%0d", tag, k), {sh_shift, sh_in}, 2'b10);
      if (!force_one)
        check($sformatf("%s_dr_out%0d", tag, k), sh_out, (k < exp_sat) ? 1 : 0);
      check($sformatf("%s_dr_done%0d", tag, k), done, 0);
      @(posedge clk); #1;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 1);
    check({tag, "_done_id"}, done_id, exp_id);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_done_rdy"}, req_ready, 0);
    check({tag, "_done_shift"}, sh_shift, 0);
    @(posedge clk); #1;
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_held_result"}, result, exp_res);
    check({tag, "_held_id"}, done_id, exp_id);
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_lb_err;
    int done_cnt;
`ifdef UNARY_SCHED_LOOPBACK_CHECK_EN
    exp_lb_err = 1'b1;
`else
    exp_lb_err = 1'b0;
`endif
    force_one = 1'b0;
    reset     = 1'b1;
    req_valid = '1;
    req_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_shift_in", {sh_shift, sh_in}, 0);
    check("rst_rdy", req_ready, 0);
    check("rst_result", result, 0);
    check("rst_done_id", done_id, 0);
    check("rst_err", err, 0);

    reset = 1'b0;
    req_valid = '0;
    #1;
    check("idle_no_req_rdy", req_ready, 0);

    // Single request, value 5.
    set_req(0, 5); #1;
    run_one("single5", 0, 5, 5, 1, 0);

    // Boundary magnitudes: zero, exactly N, above N (saturates).
    set_req(0, 0);  #1; run_one("val0",  1'b0, 0,  0,  1, 0);
    set_req(0, 16); #1; run_one("val16", 0, 16, 16, 1, 0);
    set_req(0, 20); #1; run_one("val20", 0, 16, 16, 1, 0);

    // Round-robin: all four hold valid throughout; last winner is 0.
    set_req(0, 1); set_req(1, 2); set_req(2, 3); set_req(3, 4); #1;
    run_one("rr1", 1, 2, 2, 0, 0);
    run_one("rr2", 2, 3, 3, 0, 0);
    run_one("rr3", 3, 4, 4, 0, 0);
    run_one("rr0", 0, 1, 1, 0, 0);
    run_one("rr1b", 1, 2, 2, 0, 0);
    req_valid = '0; #1;

    // Priority after last grant: req2 alone, then req1 and req3 together.
    set_req(2, 7); #1;
    run_one("p2", 2, 7, 7, 1, 0);
    set_req(1, 9); set_req(3, 2); #1;
    run_one("p3", 3, 2, 2, 1, 0);
    run_one("p1", 1, 9, 9, 1, 0);

    // Reset in LOAD cycle 7 drops the job.
    set_req(0, 9); #1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_pre_shift", sh_shift, 1);
    reset = 1'b1;
    set_req(1, 4);
    @(posedge clk); #1;
    check("abort_shift", sh_shift, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rdy", req_ready, 0);
    check("abort_result", result, 0);
    reset = 1'b0;
    req_valid = '0;
    done_cnt = 0;
    for (int c = 0; c < 2*N + 4; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    // Priority restarts at requester 0 after reset.
    set_req(0, 6); set_req(1, 11); #1;
    run_one("post_rst", 0, 6, 6, 1, 0);
    req_valid = '0; #1;

    // Loopback: sh_out forced high through the job, value 3.
    force_one = 1'b1;
    set_req(2, 3); #1;
    run_one("lb", 2, 3, 16, 1, exp_lb_err);
    force_one = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lb_err_held", err, exp_lb_err);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("lb_err_cleared", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
